id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Parametrised decode-operand stage between IF and EX. Holds the IF→ID pipeline register and keeps the synchronous-SRAM instruction word in a replay buffer while the stage is held. Resolves rs/rt operands through an N-source priority forwarding network with per-source busy (load-use) stall detection, and counts stall cycles. It is the next generation of the fixed two-source ID forwarding logic: forwarding-source count, data width and register-address width are generic.

## Interface
- `DW`, 32, operand/data width
- `AW`, 5, register address width
- `PC_W`, 32, PC width
- `NFWD`, 3, forwarding sources; index 0 = youngest (EX), highest priority
- `CNT_W`, 16, stall counter width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  kill ID contents
- `hold`  in  1  downstream (EX) cannot accept
- `if_valid`  in  1  IF presents a PC this cycle
- `if_pc`  in  PC_W  PC whose SRAM read was issued this cycle
- `inst_rdata`  in  32  SRAM data for the PC issued last cycle
- `rf_rs_rdata`, `rf_rt_rdata`  in  DW  regfile read data
- `fwd_we`  in  NFWD  source i writes a register
- `fwd_waddr`  in  NFWD*AW  slice i = destination of source i
- `fwd_wdata`  in  NFWD*DW  slice i = result of source i
- `fwd_busy`  in  NFWD  source i result not yet available (load in flight)
- `rs_addr`, `rt_addr`  out  AW  inst[25:21], inst[20:16] of the current instruction
- `id_ready`  out  1  stage advances this cycle; IF may step its PC
- `id_valid`  out  1  instruction + operands valid to EX
- `id_pc`  out  PC_W
- `id_inst`  out  32
- `id_rs_val`, `id_rt_val`  out  DW  forwarded operands
- `stallreq`  out  1  operand hazard
- `stall_cycles`  out  CNT_W  saturating hazard-stall count

## Operation
- State: `valid`, `pc`, `buf_valid`, `buf_inst`, `stall_cycles`.
- `inst = buf_valid ? buf_inst : inst_rdata`.
- `id_inst` = `inst` when `valid`, else 0.
- Forwarding, per operand (rs, rt), for address r:
  - Matching sources: `fwd_we[i] & fwd_waddr[i]==r`.
  - The lowest-index matching source wins.
  - With no match, the operand is the regfile data.
  - r==0 always yields 0 and never stalls.
- Hazard: `stallreq = valid & (winner of rs is busy | winner of rt is busy)`. A busy lower-priority source shadowed by a non-busy winner does not stall.
- `adv = ~hold & ~stallreq`; `id_ready = adv`.
- `id_valid = valid & ~stallreq & ~flush`.
- `id_pc` = `pc` when `valid`, else 0.
- `id_rs_val` / `id_rt_val` = 0 when `~valid`.
- FSM RUN/HELD, with HELD ≡ `buf_valid`. Sequential update (priority order):
  1. `flush`: `valid`←0, `pc`←0, `buf_valid`←0, `buf_inst`←0.
  2. `adv`: `valid`←`if_valid`, `pc`←`if_pc`, `buf_valid`←0 (RUN).
  3. Else, held: keep `valid`/`pc`.
     - If `valid & ~buf_valid`: `buf_inst`←`inst_rdata`, `buf_valid`←1 (RUN→HELD).
     - If already HELD, the buffer is unchanged.
- `stall_cycles` increments each cycle `stallreq`=1 and saturates at all-ones. It is cleared only by `rst`; `flush` does not clear it.

## Timing
- Reset (asynchronous, immediate): all state 0. Every output is 0 except `rs_addr`/`rt_addr` (follow `inst_rdata`) and `id_ready` (=1 while `hold`=0).
- Latency: PC accepted at edge n; `id_*` valid in cycle n+1 combinationally from `inst_rdata`.
- Forwarding and `stallreq` are combinational from that cycle's `fwd_*`. There are no extra stages.
- Held stage: `id_inst` is stable across any number of held cycles, independent of `inst_rdata`.
- `hold` and `stallreq` together: the stage holds. `id_valid`=0 while `stallreq`=1; while only `hold`=1, `id_valid` stays high.
- `flush` with `hold`: flush wins; next cycle `valid`=0, `buf_valid`=0.
- Release: the first `adv` edge loads the next PC and drops the buffer.

## Test plan
- **Async reset:** state valid with pc 0x1000; raise `rst` mid-cycle.
  - Required: `id_valid`, `id_pc`, `stallreq`, `stall_cycles` are 0 before the next clock edge.
- **Priority forwarding:** src0 and src1 both write r8 with 0x11 and 0x22; rs=r8, rt=r8, regfile data 0x99.
  - Required: `id_rs_val` = `id_rt_val` = 0x11.
  - With src0 disabled: 0x22.
- **r0 forwarding:** src0 writes r0 with 0x5; rs=r0.
  - Required: `id_rs_val`=0.
  - With `fwd_busy[0]`=1 as well: `stallreq`=0.
- **Load-use:** inst 0x01095021 (addu r10,r8,r9) at pc 0x2000; src0 `busy`=1 on r9 for 2 cycles; `inst_rdata` changes to 0xDEADBEEF.
  - Required during the 2 cycles: `stallreq`=1, `id_valid`=0, `id_ready`=0, `id_inst` stays 0x01095021, `stall_cycles`=2.
  - Then src1 forwards r9=0x33: `id_rt_val`=0x33, `id_valid`=1.
- **Shadowed busy:** src0 non-busy writes r9=0x44, src1 busy on r9.
  - Required: `stallreq`=0, `id_rt_val`=0x44.
- **Flush during hold:** `hold`=1 for 3 cycles at pc 0x3000, then `flush`=1 with `hold`=1.
  - Required next cycle: `id_valid`=0, `id_pc`=0, buffer empty (`id_inst`=0).
- **Saturation:** CNT_W=4 with 20 hazard cycles.
  - Required: `stall_cycles`=0xF, held.

Source files
------------

// File: rtl/id_operand_stage.sv
// Decode-operand stage: IF->ID pipeline register, SRAM instruction replay buffer,
// N-source priority operand forwarding with load-use stall detection and a stall counter.
module id_operand_stage #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int PC_W  = 32,
    parameter int NFWD  = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 hold,
    input  logic                 if_valid,
    input  logic [PC_W-1:0]      if_pc,
    input  logic [31:0]          inst_rdata,
    input  logic [DW-1:0]        rf_rs_rdata,
    input  logic [DW-1:0]        rf_rt_rdata,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD*AW-1:0]   fwd_waddr,
    input  logic [NFWD*DW-1:0]   fwd_wdata,
    input  logic [NFWD-1:0]      fwd_busy,
    output logic [AW-1:0]        rs_addr,
    output logic [AW-1:0]        rt_addr,
    output logic                 id_ready,
    output logic                 id_valid,
    output logic [PC_W-1:0]      id_pc,
    output logic [31:0]          id_inst,
    output logic [DW-1:0]        id_rs_val,
    output logic [DW-1:0]        id_rt_val,
    output logic                 stallreq,
    output logic [CNT_W-1:0]     stall_cycles
);

    // Handshake: the stage hands an instruction to EX when id_valid is high, and
    // advances (id_ready) whenever EX is not holding and no operand is still in flight.

    typedef enum logic {
        RUN  = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t             state;
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [31:0]        buf_inst;
    logic [CNT_W-1:0]   cnt;

    logic               buf_valid;
    logic [31:0]        inst;
    logic               adv;
    logic [DW-1:0]      rs_fwd_val;
    logic [DW-1:0]      rt_fwd_val;
    logic               rs_fwd_busy;
    logic               rt_fwd_busy;

    assign buf_valid = (state == HELD);

    // The SRAM only presents the word for one cycle; once held, replay it from the buffer.
    assign inst    = buf_valid ? buf_inst : inst_rdata;
    assign rs_addr = AW'(inst[25:21]);
    assign rt_addr = AW'(inst[20:16]);

    // Scan from lowest to highest priority so the youngest matching source ends up winning.
    function automatic logic [DW:0] resolve(
        input logic [AW-1:0]      r,
        input logic [DW-1:0]      rf,
        input logic [NFWD-1:0]    we,
        input logic [NFWD*AW-1:0] waddr,
        input logic [NFWD*DW-1:0] wdata,
        input logic [NFWD-1:0]    busy
    );
        logic [DW:0] res;
        res = {1'b0, rf};
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (we[i] && (waddr[i*AW +: AW] == r)) begin
                res = {busy[i], wdata[i*DW +: DW]};
            end
        end
        if (r == '0) begin
            res = '0;
        end
        return res;
    endfunction

    always_comb begin
        {rs_fwd_busy, rs_fwd_val} = resolve(rs_addr, rf_rs_rdata, fwd_we, fwd_waddr,
                                            fwd_wdata, fwd_busy);
        {rt_fwd_busy, rt_fwd_val} = resolve(rt_addr, rf_rt_rdata, fwd_we, fwd_waddr,
                                            fwd_wdata, fwd_busy);
    end

    assign stallreq  = valid & (rs_fwd_busy | rt_fwd_busy);
    assign adv       = ~hold & ~stallreq;
    assign id_ready  = adv;
    assign id_valid  = valid & ~stallreq & ~flush;
    assign id_pc     = valid ? pc : '0;
    assign id_inst   = valid ? inst : 32'h0;
    assign id_rs_val = valid ? rs_fwd_val : '0;
    assign id_rt_val = valid ? rt_fwd_val : '0;

    // Flush beats advance, advance beats hold; a held stage captures the SRAM word once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            valid    <= 1'b0;
            pc       <= '0;
            buf_inst <= 32'h0;
        end else if (flush) begin
            state    <= RUN;
            valid    <= 1'b0;
            pc       <= '0;
            buf_inst <= 32'h0;
        end else if (adv) begin
            state    <= RUN;
            valid    <= if_valid;
            pc       <= if_pc;
        end else begin
            case (state)
                RUN: begin
                    if (valid) begin
                        buf_inst <= inst_rdata;
                        state    <= HELD;
                    end
                end
                HELD: begin
                    state <= HELD;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Survives flush so it reflects total hazard cycles since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (stallreq && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stall_cycles = cnt;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed hazard/forwarding scenarios plus random traffic,
// scored against a behavioural model of the stage.
module tb_id_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int PC_W = 32;
    localparam int NFWD = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic hold = 1'b0;
    logic if_valid = 1'b0;
    logic [PC_W-1:0] if_pc = '0;
    logic [31:0] inst_rdata = '0;
    logic [DW-1:0] rf_rs_rdata = '0;
    logic [DW-1:0] rf_rt_rdata = '0;
    logic fw_we [NFWD];
    logic [AW-1:0] fw_addr [NFWD];
    logic [DW-1:0] fw_data [NFWD];
    logic fw_busy [NFWD];

    logic [NFWD-1:0] fwd_we;
    logic [NFWD*AW-1:0] fwd_waddr;
    logic [NFWD*DW-1:0] fwd_wdata;
    logic [NFWD-1:0] fwd_busy;

    for (genvar g = 0; g < NFWD; g++) begin : g_pack
        assign fwd_we[g] = fw_we[g];
        assign fwd_waddr[g*AW +: AW] = fw_addr[g];
        assign fwd_wdata[g*DW +: DW] = fw_data[g];
        assign fwd_busy[g] = fw_busy[g];
    end

    logic [AW-1:0] rs_addr, rt_addr, s_rs_addr, s_rt_addr;
    logic id_ready, id_valid, stallreq, s_id_ready, s_id_valid, s_stallreq;
    logic [PC_W-1:0] id_pc, s_id_pc;
    logic [31:0] id_inst, s_id_inst;
    logic [DW-1:0] id_rs_val, id_rt_val, s_id_rs_val, s_id_rt_val;
    logic [15:0] stall_cycles;
    logic [3:0] s_stall_cycles;

    id_operand_stage #(.DW(DW), .AW(AW), .PC_W(PC_W), .NFWD(NFWD), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold), .if_valid(if_valid),
        .if_pc(if_pc), .inst_rdata(inst_rdata), .rf_rs_rdata(rf_rs_rdata),
        .rf_rt_rdata(rf_rt_rdata), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .fwd_busy(fwd_busy), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .stallreq(stallreq),
        .stall_cycles(stall_cycles)
    );

    // Narrow-counter copy fed the same stimulus, for saturation.
    id_operand_stage #(.DW(DW), .AW(AW), .PC_W(PC_W), .NFWD(NFWD), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold), .if_valid(if_valid),
        .if_pc(if_pc), .inst_rdata(inst_rdata), .rf_rs_rdata(rf_rs_rdata),
        .rf_rt_rdata(rf_rt_rdata), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .fwd_busy(fwd_busy), .rs_addr(s_rs_addr),
        .rt_addr(s_rt_addr), .id_ready(s_id_ready), .id_valid(s_id_valid),
        .id_pc(s_id_pc), .id_inst(s_id_inst), .id_rs_val(s_id_rs_val),
        .id_rt_val(s_id_rt_val), .stallreq(s_stallreq), .stall_cycles(s_stall_cycles)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    bit m_valid;
    logic [PC_W-1:0] m_pc;
    bit m_held;
    logic [31:0] m_word;
    int m_cnt;
    bit e_stall, e_ready;

    task automatic ref_operand(input logic [AW-1:0] r, input logic [DW-1:0] rf,
                               output logic [DW-1:0] v, output bit b);
        bit found;
        found = 0;
        v = rf;
        b = 0;
        for (int i = 0; i < NFWD; i++) begin
            if (!found && fw_we[i] && fw_addr[i] == r) begin
                found = 1;
                v = fw_data[i];
                b = fw_busy[i];
            end
        end
        if (r == 0) begin
            v = 0;
            b = 0;
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_pc = 0;
        m_held = 0;
        m_word = 0;
        m_cnt = 0;
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Compare every output of both instances against the model for the current cycle.
    task automatic cycle_begin();
        logic [31:0] w;
        logic [DW-1:0] rsv, rtv;
        bit rsb, rtb;
        bit e_valid;
        #2;
        w = m_held ? m_word : inst_rdata;
        ref_operand(w[25:21], rf_rs_rdata, rsv, rsb);
        ref_operand(w[20:16], rf_rt_rdata, rtv, rtb);
        e_stall = m_valid && (rsb || rtb);
        e_ready = !hold && !e_stall;
        e_valid = m_valid && !e_stall && !flush;
        check("rs_addr", rs_addr, w[25:21]);
        check("rt_addr", rt_addr, w[20:16]);
        check("stallreq", stallreq, e_stall);
        check("id_ready", id_ready, e_ready);
        check("id_valid", id_valid, e_valid);
        check("id_pc", id_pc, m_valid ? m_pc : 0);
        check("id_inst", id_inst, m_valid ? w : 0);
        check("id_rs_val", id_rs_val, m_valid ? rsv : 0);
        check("id_rt_val", id_rt_val, m_valid ? rtv : 0);
        check("stall_cycles", stall_cycles, sat(m_cnt, 16'hFFFF));
        check("sat_stall_cycles", s_stall_cycles, sat(m_cnt, 15));
        check("sat_stallreq", s_stallreq, e_stall);
        check("sat_id_ready", s_id_ready, e_ready);
        check("sat_id_valid", s_id_valid, e_valid);
        check("sat_id_pc", s_id_pc, m_valid ? m_pc : 0);
        check("sat_id_inst", s_id_inst, m_valid ? w : 0);
        check("sat_rs", {s_rs_addr, s_rt_addr}, {w[25:21], w[20:16]});
        check("sat_vals", {s_id_rs_val, s_id_rt_val}, m_valid ? {rsv, rtv} : 64'h0);
    endtask

    task automatic cycle_end();
        if (e_stall) m_cnt++;
        if (flush) begin
            m_valid = 0;
            m_pc = 0;
            m_held = 0;
            m_word = 0;
        end else if (e_ready) begin
            m_valid = if_valid;
            m_pc = if_pc;
            m_held = 0;
        end else if (m_valid && !m_held) begin
            m_word = inst_rdata;
            m_held = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Driver tasks
    task automatic clear_fwd();
        for (int i = 0; i < NFWD; i++) begin
            fw_we[i] = 0;
            fw_addr[i] = 0;
            fw_data[i] = 0;
            fw_busy[i] = 0;
        end
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic b);
        fw_we[i] = 1;
        fw_addr[i] = a;
        fw_data[i] = d;
        fw_busy[i] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Accept a PC at the coming edge with a quiet forwarding network.
    task automatic load_pc(input logic [PC_W-1:0] p);
        clear_fwd();
        hold = 0;
        flush = 0;
        if_valid = 1;
        if_pc = p;
        cycle_begin();
        cycle_end();
        if_valid = 0;
        if_pc = 0;
    endtask

    initial begin
        clear_fwd();
        @(negedge clk);

        // Reset values
        rst = 1'b1;
        inst_rdata = 32'h01095021;
        model_reset();
        #2;
        check("reset_id_valid", id_valid, 0);
        check("reset_id_pc", id_pc, 0);
        check("reset_stall_cycles", stall_cycles, 0);
        check("reset_id_ready", id_ready, 1);
        check("reset_rs_addr", rs_addr, 8);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset mid-cycle
        load_pc(32'h1000);
        cycle_begin();
        check("pre_rst_id_pc", id_pc, 32'h1000);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_id_valid", id_valid, 0);
        check("async_rst_id_pc", id_pc, 0);
        check("async_rst_stallreq", stallreq, 0);
        check("async_rst_stall_cycles", stall_cycles, 0);
        @(negedge clk);
        rst = 1'b0;

        // Priority forwarding
        load_pc(32'h1100);
        if_valid = 1;
        if_pc = 32'h1104;
        inst_rdata = 32'h01080000;
        rf_rs_rdata = 32'h99;
        rf_rt_rdata = 32'h99;
        set_src(0, 8, 32'h11, 0);
        set_src(1, 8, 32'h22, 0);
        cycle_begin();
        check("prio_rs", id_rs_val, 32'h11);
        check("prio_rt", id_rt_val, 32'h11);
        cycle_end();
        fw_we[0] = 0;
        cycle_begin();
        check("prio_src0_off_rs", id_rs_val, 32'h22);
        check("prio_src0_off_rt", id_rt_val, 32'h22);
        cycle_end();

        // r0 never forwards and never stalls
        clear_fwd();
        inst_rdata = 32'h00090000;
        set_src(0, 0, 32'h5, 0);
        cycle_begin();
        check("r0_rs_val", id_rs_val, 0);
        cycle_end();
        fw_busy[0] = 1;
        cycle_begin();
        check("r0_busy_stallreq", stallreq, 0);
        cycle_end();

        // Load-use stall with replay buffer
        load_pc(32'h2000);
        inst_rdata = 32'h01095021;
        rf_rs_rdata = 32'h8888;
        rf_rt_rdata = 32'h9999;
        set_src(0, 9, 32'h0, 1);
        for (int c = 0; c < 2; c++) begin
            cycle_begin();
            check("lu_stallreq", stallreq, 1);
            check("lu_id_valid", id_valid, 0);
            check("lu_id_ready", id_ready, 0);
            check("lu_id_inst", id_inst, 32'h01095021);
            cycle_end();
            inst_rdata = 32'hDEADBEEF;
        end
        clear_fwd();
        set_src(1, 9, 32'h33, 0);
        if_valid = 1;
        if_pc = 32'h2004;
        cycle_begin();
        check("lu_stall_cycles", stall_cycles, 2);
        check("lu_fwd_rt", id_rt_val, 32'h33);
        check("lu_id_valid_after", id_valid, 1);
        check("lu_id_inst_after", id_inst, 32'h01095021);
        cycle_end();

        // Shadowed busy source
        if_valid = 0;
        inst_rdata = 32'h01095021;
        clear_fwd();
        set_src(0, 9, 32'h44, 0);
        set_src(1, 9, 32'h55, 1);
        cycle_begin();
        check("shadow_stallreq", stallreq, 0);
        check("shadow_rt", id_rt_val, 32'h44);
        cycle_end();

        // Flush during hold
        load_pc(32'h3000);
        inst_rdata = 32'h00421820;
        hold = 1;
        for (int c = 0; c < 3; c++) begin
            cycle_begin();
            check("hold_id_valid", id_valid, 1);
            check("hold_id_pc", id_pc, 32'h3000);
            check("hold_id_inst", id_inst, 32'h00421820);
            cycle_end();
            inst_rdata = $urandom;
        end
        flush = 1;
        cycle_begin();
        check("flush_id_valid_now", id_valid, 0);
        cycle_end();
        flush = 0;
        cycle_begin();
        check("flush_id_valid", id_valid, 0);
        check("flush_id_pc", id_pc, 0);
        check("flush_id_inst", id_inst, 0);
        cycle_end();
        hold = 0;

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            logic [31:0] w;
            w = $urandom;
            w[25:21] = 5'($urandom_range(0, 3));
            w[20:16] = 5'($urandom_range(0, 3));
            inst_rdata = w;
            rf_rs_rdata = $urandom;
            rf_rt_rdata = $urandom;
            hold = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 19) == 0);
            if_valid = ($urandom_range(0, 4) != 0);
            if_pc = $urandom;
            for (int i = 0; i < NFWD; i++) begin
                fw_we[i] = $urandom_range(0, 1);
                fw_addr[i] = 5'($urandom_range(0, 3));
                fw_data[i] = $urandom;
                fw_busy[i] = ($urandom_range(0, 3) == 0);
            end
            cycle_begin();
            cycle_end();
        end
        flush = 0;
        hold = 0;

        // Counter saturation on the narrow instance
        do_reset();
        load_pc(32'h4000);
        inst_rdata = 32'h01095021;
        set_src(0, 9, 32'h0, 1);
        for (int c = 0; c < 20; c++) begin
            cycle_begin();
            cycle_end();
        end
        clear_fwd();
        cycle_begin();
        check("sat_held_value", s_stall_cycles, 4'hF);
        check("wide_count_20", stall_cycles, 20);
        cycle_end();
        cycle_begin();
        check("sat_still_held", s_stall_cycles, 4'hF);
        cycle_end();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
